geiger_count_packer: RTL and testbench



---
 rtl/geiger_count_packer.sv | 138 +++++++++++++
 tb/tb_geiger_count_packer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/geiger_count_packer.sv
// ----------------------------------------------------------------------------
// geiger_count_packer
//
// Counts pulses from two Geiger tube discriminators over a fixed integration
// window and packs each window's result into a 48-bit record:
//     GEIGER_DATA = {SEQ[15:0], COUNT_A[15:0], COUNT_B[15:0]}
// SEQ increments on every record so that consecutive records always differ.
//
// Parameters
//   WINDOW_CYCLES   integration window length in CLK_1MHZ cycles (2..2^24)
//   DEADTIME_CYCLES per-channel dead time after an accepted pulse (0 = off)
//
// Ports
//   CLK_1MHZ     in   1  system clock
//   RESET        in   1  asynchronous, active-low reset
//   GEIGER_A     in   1  tube A discriminator pulse (asynchronous)
//   GEIGER_B     in   1  tube B discriminator pulse (asynchronous)
//   GEIGER_DATA  out 48  packed record, held between window closes
//   DATA_VALID   out  1  one-cycle strobe when a new record is presented
// ----------------------------------------------------------------------------
module geiger_count_packer #(
    parameter int unsigned WINDOW_CYCLES   = 1000000,
    parameter int unsigned DEADTIME_CYCLES = 50
) (
    input  logic        CLK_1MHZ,
    input  logic        RESET,
    input  logic        GEIGER_A,
    input  logic        GEIGER_B,
    output logic [47:0] GEIGER_DATA,
    output logic        DATA_VALID
);

    localparam int WIN_W = $clog2(WINDOW_CYCLES);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

    // A dead time of 0 or 1 cycle never blocks a following edge (edges are
    // at least one cycle apart), so the counter degenerates to a constant 0.
    localparam int DEAD_W = (DEADTIME_CYCLES > 1) ? $clog2(DEADTIME_CYCLES) : 1;
    localparam logic [DEAD_W-1:0] DEAD_LOAD =
        (DEADTIME_CYCLES > 1) ? DEAD_W'(DEADTIME_CYCLES - 1) : '0;

    // Channel 0 is tube A, channel 1 is tube B.
    logic [1:0] geiger_in;
    logic [1:0] accept;

    assign geiger_in = {GEIGER_B, GEIGER_A};

    // ------------------------------------------------------------------------
    // Per-channel conditioning: 2-flop synchronizer, registered rising-edge
    // detect, and dead-time filter. An edge sampled at clock edge t is seen
    // in edge_reg after t+2 and therefore counted at t+3.
    // ------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic              sync1_reg;
            logic              sync2_reg;
            logic              prev_reg;
            logic              edge_reg;
            logic [DEAD_W-1:0] dead_reg;
            logic              accept_now;

            assign accept_now = edge_reg && (dead_reg == '0);
            assign accept[gi] = accept_now;

            always_ff @(posedge CLK_1MHZ or negedge RESET) begin
                if (!RESET) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    prev_reg  <= 1'b0;
                    edge_reg  <= 1'b0;
                    dead_reg  <= '0;
                end else begin
                    sync1_reg <= geiger_in[gi];
                    sync2_reg <= sync1_reg;
                    prev_reg  <= sync2_reg;
                    edge_reg  <= sync2_reg & ~prev_reg;
                    // Dead time deliberately ignores window boundaries.
                    if (accept_now) begin
                        dead_reg <= DEAD_LOAD;
                    end else if (dead_reg != '0) begin
                        dead_reg <= dead_reg - 1'b1;
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Accumulators, window counter and record register
    // ------------------------------------------------------------------------
    logic [1:0][15:0] acc_reg;
    logic [1:0][15:0] acc_next;
    logic [WIN_W-1:0] win_cnt_reg;
    logic [15:0]      seq_reg;
    logic [47:0]      data_reg;
    logic             valid_reg;
    logic             window_close;

    assign window_close = (win_cnt_reg == WIN_LAST);

    // Saturating increment; includes an edge accepted on the close cycle so
    // that it lands in the closing record rather than the next window.
    always_comb begin
        acc_next = acc_reg;
        for (int i = 0; i < 2; i++) begin
            if (accept[i] && (acc_reg[i] != 16'hFFFF)) begin
                acc_next[i] = acc_reg[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK_1MHZ or negedge RESET) begin
        if (!RESET) begin
            acc_reg     <= '0;
            win_cnt_reg <= '0;
            seq_reg     <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
        end else begin
            if (window_close) begin
                win_cnt_reg <= '0;
                seq_reg     <= seq_reg + 16'd1;
                data_reg    <= {seq_reg + 16'd1, acc_next[0], acc_next[1]};
                acc_reg     <= '0;
                valid_reg   <= 1'b1;
            end else begin
                win_cnt_reg <= win_cnt_reg + 1'b1;
                acc_reg     <= acc_next;
                valid_reg   <= 1'b0;
            end
        end
    end

    assign GEIGER_DATA = data_reg;
    assign DATA_VALID  = valid_reg;

endmodule

// File: tb/tb_geiger_count_packer.sv
// ----------------------------------------------------------------------------
// tb_geiger_count_packer
//
// Two instances share one clock: u0 (100-cycle window, no dead time) and
// u1 (100-cycle window, 5-cycle dead time). Inputs are driven and outputs
// sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_geiger_count_packer;

    localparam int W  = 100;
    localparam int D1 = 5;
    localparam int NW = 6;
    localparam int NR = W * NW;

    logic        clk;
    logic        rst0, ga0, gb0, valid0;
    logic        rst1, ga1, gb1, valid1;
    logic [47:0] data0, data1;

    int vectors;
    int miscompares;

    geiger_count_packer #(.WINDOW_CYCLES(W), .DEADTIME_CYCLES(0)) u0 (
        .CLK_1MHZ   (clk),
        .RESET      (rst0),
        .GEIGER_A   (ga0),
        .GEIGER_B   (gb0),
        .GEIGER_DATA(data0),
        .DATA_VALID (valid0)
    );

    geiger_count_packer #(.WINDOW_CYCLES(W), .DEADTIME_CYCLES(D1)) u1 (
        .CLK_1MHZ   (clk),
        .RESET      (rst1),
        .GEIGER_A   (ga1),
        .GEIGER_B   (gb1),
        .GEIGER_DATA(data1),
        .DATA_VALID (valid1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          na;
        int          nb;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } vec_t;

    vec_t tbl [7];

    task automatic check48(input string name, input logic [47:0] act, input logic [47:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Wait (bounded) for a strobe on the chosen instance, check the elapsed
    // falling edges (if exp_n > 0), the record, and that the strobe lasts
    // exactly one cycle. Returns one falling edge after the strobe.
    task automatic wait_record(input int inst, input int exp_n,
                               input logic [47:0] exp_data, input string name);
        int          n;
        logic        v;
        logic [47:0] d;
        n = 0;
        v = 1'b0;
        while (!v && n < 400) begin
            @(negedge clk);
            n++;
            v = (inst == 0) ? valid0 : valid1;
        end
        d = (inst == 0) ? data0 : data1;
        check_int({name, " strobe seen"}, int'(v), 1);
        if (exp_n > 0) check_int({name, " cycles"}, n, exp_n);
        check48({name, " data"}, d, exp_data);
        @(negedge clk);
        v = (inst == 0) ? valid0 : valid1;
        check_int({name, " strobe width"}, int'(v), 0);
    endtask

    // Slot i: A and/or B high for 2 cycles, then low for 2 cycles.
    task automatic drive_slots(input int na, input int nb);
        int ns;
        ns = (na > nb) ? na : nb;
        for (int i = 0; i < ns; i++) begin
            ga0 = (i < na);
            gb0 = (i < nb);
            repeat (2) @(negedge clk);
            ga0 = 1'b0;
            gb0 = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    logic [15:0] seq_exp;
    logic        w   [2][NR];
    int          cnt [2][NW];
    logic [20:0] pat;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst0 = 1'b0; ga0 = 1'b0; gb0 = 1'b0;
        rst1 = 1'b0; ga1 = 1'b0; gb1 = 1'b0;

        tbl[0] = '{na: 7,  nb: 3,  exp_a: 16'd7,  exp_b: 16'd3};
        tbl[1] = '{na: 0,  nb: 0,  exp_a: 16'd0,  exp_b: 16'd0};
        tbl[2] = '{na: 1,  nb: 0,  exp_a: 16'd1,  exp_b: 16'd0};
        tbl[3] = '{na: 0,  nb: 5,  exp_a: 16'd0,  exp_b: 16'd5};
        tbl[4] = '{na: 12, nb: 12, exp_a: 16'd12, exp_b: 16'd12};
        tbl[5] = '{na: 20, nb: 4,  exp_a: 16'd20, exp_b: 16'd4};
        tbl[6] = '{na: 3,  nb: 10, exp_a: 16'd3,  exp_b: 16'd10};

        // ---------------- reset state and record cadence ----------------
        repeat (3) @(negedge clk);
        check48("reset data", data0, 48'h0);
        check_int("reset valid", int'(valid0), 0);
        rst0 = 1'b1;
        for (int r = 1; r <= 3; r++) begin
            wait_record(0, (r == 1) ? W : W - 1, {16'(r), 32'h0}, "cadence");
        end
        seq_exp = 16'd4;

        // ---------------- table: counting and channel independence --------
        for (int i = 0; i < 7; i++) begin
            drive_slots(tbl[i].na, tbl[i].nb);
            wait_record(0, -1, {seq_exp, tbl[i].exp_a, tbl[i].exp_b}, "table");
            seq_exp++;
        end

        // ---------------- boundary: edge counted on the close cycle -------
        // Next value applies to window edge 1; edge 96 is counted at 99.
        repeat (95) @(negedge clk);
        ga0 = 1'b1; repeat (2) @(negedge clk); ga0 = 1'b0;
        wait_record(0, -1, {seq_exp, 16'd1, 16'd0}, "boundary close");
        seq_exp++;
        // Edge 97 is counted at 100, i.e. the first cycle of the next window.
        repeat (96) @(negedge clk);
        ga0 = 1'b1; repeat (2) @(negedge clk); ga0 = 1'b0;
        wait_record(0, -1, {seq_exp, 16'd0, 16'd0}, "boundary after");
        seq_exp++;
        wait_record(0, -1, {seq_exp, 16'd1, 16'd0}, "boundary spill");
        seq_exp++;

        // ---------------- saturation at the close cycle -------------------
        force u0.acc_reg = {16'h1234, 16'hFFFF};
        repeat (95) @(negedge clk);
        ga0 = 1'b1; gb0 = 1'b1; repeat (2) @(negedge clk); ga0 = 1'b0; gb0 = 1'b0;
        wait_record(0, -1, {seq_exp, 16'hFFFF, 16'h1235}, "saturate");
        release u0.acc_reg;
        seq_exp++;

        // ---------------- reset mid-window --------------------------------
        drive_slots(20, 0);
        #2 rst0 = 1'b0;
        #1;
        check48("mid reset data", data0, 48'h0);
        check_int("mid reset valid", int'(valid0), 0);
        @(negedge clk);
        rst0 = 1'b1;
        wait_record(0, W, {16'h0001, 32'h0}, "after reset");

        // ---------------- SEQ wrap ----------------------------------------
        force u0.seq_reg = 16'hFFFF;
        wait_record(0, W - 1, {16'h0000, 32'h0}, "seq wrap");
        release u0.seq_reg;

        // ---------------- dead time (u1) ----------------------------------
        @(negedge clk);
        rst1 = 1'b1;
        wait_record(1, W, {16'h0001, 32'h0}, "dead first");
        // Rising edges at window edges 10, 13 and 15.
        pat = '0;
        pat[10] = 1'b1; pat[11] = 1'b1; pat[13] = 1'b1; pat[15] = 1'b1; pat[16] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            ga1 = pat[k];
            @(negedge clk);
        end
        ga1 = 1'b0;
        wait_record(1, -1, {16'h0002, 16'd2, 16'd0}, "dead time");

        // ---------------- randomized run against edge-time model (u1) -----
        for (int ch = 0; ch < 2; ch++) begin
            int   t;
            logic lvl;
            t   = 0;
            lvl = 1'b0;
            while (t < NR) begin
                int len;
                len = lvl ? int'($urandom_range(2, 4)) : int'($urandom_range(1, 9));
                for (int j = 0; j < len && t < NR; j++) begin
                    w[ch][t] = lvl;
                    t++;
                end
                lvl = ~lvl;
            end
            for (int n = 0; n < NW; n++) cnt[ch][n] = 0;
        end

        // Model: an edge driven for clock edge t is counted at t+3; it is
        // accepted if at least D1 cycles after the previous accepted edge;
        // it belongs to window (t+3)/W.
        for (int ch = 0; ch < 2; ch++) begin
            int last;
            last = -1000;
            for (int t = 0; t < NR; t++) begin
                if (w[ch][t] && (t == 0 || !w[ch][t-1])) begin
                    int c;
                    c = t + 3;
                    if (c - last >= D1) begin
                        last = c;
                        if (c / W < NW) cnt[ch][c / W]++;
                    end
                end
            end
        end

        #2 rst1 = 1'b0;
        @(negedge clk);
        rst1 = 1'b1;
        ga1  = w[0][0];
        gb1  = w[1][0];
        for (int t = 0; t < NR; t++) begin
            @(negedge clk);
            check_int($sformatf("random valid t=%0d", t), int'(valid1), int'(t % W == W - 1));
            if (t % W == W - 1) begin
                int n;
                n = t / W + 1;
                check48($sformatf("random record %0d", n), data1,
                        {16'(n), 16'(cnt[0][n-1]), 16'(cnt[1][n-1])});
            end
            if (t + 1 < NR) begin
                ga1 = w[0][t+1];
                gb1 = w[1][t+1];
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
